// File: rtl/cernbe_regbank_submap.sv
// CERN-BE bus slave with N_REGS read/write registers and one CERN-BE submap port.
// It also provides per-register write pulses, a submap timeout with sticky flag, and read-behind-write queuing.
module cernbe_regbank_submap #(
   parameter int                DATA_W  = 32,
   parameter int                AW      = 3,
   parameter int                N_REGS  = 4,
   parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}},
   parameter int                TIMEOUT = 255
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic [AW+1:2]              VMEAddr,
   output logic [DATA_W-1:0]          VMERdData,
   input  logic [DATA_W-1:0]          VMEWrData,
   input  logic                       VMERdMem,
   input  logic                       VMEWrMem,
   output logic                       VMERdDone,
   output logic                       VMEWrDone,
   output logic [N_REGS*DATA_W-1:0]   regs_o,
   output logic [N_REGS-1:0]          regs_wr_o,
   output logic [AW-2:0]              sm_VMEAddr_o,
   input  logic [DATA_W-1:0]          sm_VMERdData_i,
   output logic [DATA_W-1:0]          sm_VMEWrData_o,
   output logic                       sm_VMERdMem_o,
   output logic                       sm_VMEWrMem_o,
   input  logic                       sm_VMERdDone_i,
   input  logic                       sm_VMEWrDone_i,
   output logic                       timeout_o,
   input  logic                       timeout_clr_i
);

   localparam int          IDX_W = AW - 1;
   localparam logic [15:0] TMO_L = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REG     = 2'd1,
      ST_SM_WAIT = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                launch_s;
   logic                launch_wr_s;
   logic [AW+1:2]       launch_addr_s;
   logic                queue_rd_s;
   logic                sm_ack_s;
   logic                sm_tmo_s;
   logic [AW+1:2]       req_addr_r;
   logic                req_wr_r;
   logic [DATA_W-1:0]   req_data_r;
   logic                pend_r;
   logic [AW+1:2]       pend_addr_r;
   logic [15:0]         cnt_r;
   logic [DATA_W-1:0]   regs_r [N_REGS];
   logic [IDX_W-1:0]    reg_idx_s;
   logic [DATA_W-1:0]   rd_mux_s;

   assign reg_idx_s = req_addr_r[AW:2];

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a queued read takes precedence over fresh strobes once back in IDLE
   always_comb begin
      state_nxt_s   = state_r;
      launch_s      = 1'b0;
      launch_wr_s   = 1'b0;
      launch_addr_s = VMEAddr;
      queue_rd_s    = 1'b0;
      sm_ack_s      = 1'b0;
      sm_tmo_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pend_r) begin
               launch_s      = 1'b1;
               launch_addr_s = pend_addr_r;
            end else if (VMEWrMem) begin
               launch_s    = 1'b1;
               launch_wr_s = 1'b1;
               queue_rd_s  = VMERdMem;
            end else if (VMERdMem) begin
               launch_s = 1'b1;
            end else begin
               launch_s = 1'b0;
            end
            if (!launch_s) begin
               state_nxt_s = ST_IDLE;
            end else if (launch_addr_s[AW+1]) begin
               state_nxt_s = ST_SM_WAIT;
            end else begin
               state_nxt_s = ST_REG;
            end
         end
         ST_REG: begin
            state_nxt_s = ST_IDLE;
         end
         ST_SM_WAIT: begin
            if (req_wr_r) begin
               sm_ack_s = sm_VMEWrDone_i;
            end else begin
               sm_ack_s = sm_VMERdDone_i;
            end
            // an ack in the same cycle as the limit still counts as a normal completion
            if (sm_ack_s) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == TMO_L) begin
               sm_tmo_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SM_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Request capture and the single pending-read slot
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         req_addr_r  <= {AW{1'b0}};
         req_wr_r    <= 1'b0;
         req_data_r  <= {DATA_W{1'b0}};
         pend_r      <= 1'b0;
         pend_addr_r <= {AW{1'b0}};
      end else begin
         if (launch_s) begin
            req_addr_r <= launch_addr_s;
            req_wr_r   <= launch_wr_s;
            req_data_r <= VMEWrData;
         end else begin
            req_addr_r <= req_addr_r;
         end
         if (queue_rd_s) begin
            pend_r      <= 1'b1;
            pend_addr_r <= VMEAddr;
         end else if (launch_s) begin
            pend_r <= 1'b0;
         end else begin
            pend_r <= pend_r;
         end
      end
   end

   // Register file and one-cycle write pulses; unmapped indices match no register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_r[i] <= RST_VAL;
         end
         regs_wr_o <= {N_REGS{1'b0}};
      end else begin
         for (int i = 0; i < N_REGS; i++) begin
            if (state_r == ST_REG && req_wr_r && reg_idx_s == IDX_W'(i)) begin
               regs_r[i]    <= req_data_r;
               regs_wr_o[i] <= 1'b1;
            end else begin
               regs_wr_o[i] <= 1'b0;
            end
         end
      end
   end

   // Read multiplexer; unmapped indices read as zero
   always_comb begin
      rd_mux_s = {DATA_W{1'b0}};
      for (int i = 0; i < N_REGS; i++) begin
         if (reg_idx_s == IDX_W'(i)) begin
            rd_mux_s = regs_r[i];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
   end

   // Flattened register view
   always_comb begin
      regs_o = {(N_REGS*DATA_W){1'b0}};
      for (int i = 0; i < N_REGS; i++) begin
         regs_o[i*DATA_W +: DATA_W] = regs_r[i];
      end
   end

   // Bus acknowledges and read data
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         VMERdDone <= 1'b0;
         VMEWrDone <= 1'b0;
         VMERdData <= {DATA_W{1'b0}};
      end else begin
         VMERdDone <= 1'b0;
         VMEWrDone <= 1'b0;
         if (state_r == ST_REG) begin
            if (req_wr_r) begin
               VMEWrDone <= 1'b1;
            end else begin
               VMERdDone <= 1'b1;
               VMERdData <= rd_mux_s;
            end
         end else if (sm_ack_s || sm_tmo_s) begin
            if (req_wr_r) begin
               VMEWrDone <= 1'b1;
            end else begin
               VMERdDone <= 1'b1;
               VMERdData <= sm_ack_s ? sm_VMERdData_i : {DATA_W{1'b1}};
            end
         end else begin
            VMERdData <= VMERdData;
         end
      end
   end

   // Submap strobes, held address/data and wait counter
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sm_VMERdMem_o  <= 1'b0;
         sm_VMEWrMem_o  <= 1'b0;
         sm_VMEAddr_o   <= {IDX_W{1'b0}};
         sm_VMEWrData_o <= {DATA_W{1'b0}};
         cnt_r          <= 16'd0;
      end else begin
         sm_VMERdMem_o <= 1'b0;
         sm_VMEWrMem_o <= 1'b0;
         if (launch_s && launch_addr_s[AW+1]) begin
            sm_VMEWrMem_o <= launch_wr_s;
            sm_VMERdMem_o <= ~launch_wr_s;
            sm_VMEAddr_o  <= launch_addr_s[AW:2];
            cnt_r         <= 16'd0;
            if (launch_wr_s) begin
               sm_VMEWrData_o <= VMEWrData;
            end else begin
               sm_VMEWrData_o <= sm_VMEWrData_o;
            end
         end else if (state_r == ST_SM_WAIT) begin
            cnt_r <= cnt_r + 16'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Sticky timeout flag; a new timeout wins over a simultaneous clear
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         timeout_o <= 1'b0;
      end else if (sm_tmo_s) begin
         timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= timeout_o;
      end
   end

endmodule

// File: tb/tb_cernbe_regbank_submap.sv
// Self-checking bench for cernbe_regbank_submap: directed cases followed by random traffic,
// checked against a cycle-timing reference model of registers, submap latency and timeout.
module tb_cernbe_regbank_submap;

   localparam int          DW   = 32;
   localparam int          NREG = 3;
   localparam int          TMO  = 16;
   localparam logic [31:0] RSTV = 32'h12345678;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [2:0]    VMEAddr;
   logic [31:0]   VMERdData;
   logic [31:0]   VMEWrData;
   logic          VMERdMem;
   logic          VMEWrMem;
   logic          VMERdDone;
   logic          VMEWrDone;
   logic [95:0]   regs_o;
   logic [2:0]    regs_wr_o;
   logic [1:0]    sm_VMEAddr_o;
   logic [31:0]   sm_VMERdData_i;
   logic [31:0]   sm_VMEWrData_o;
   logic          sm_VMERdMem_o;
   logic          sm_VMEWrMem_o;
   logic          sm_VMERdDone_i;
   logic          sm_VMEWrDone_i;
   logic          timeout_o;
   logic          timeout_clr_i;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   mdl [NREG];
   bit            tmo_flag;

   cernbe_regbank_submap #(
      .DATA_W(DW), .AW(3), .N_REGS(NREG), .RST_VAL(RSTV), .TIMEOUT(TMO)
   ) dut (
      .Clk(Clk), .Rst(Rst), .VMEAddr(VMEAddr), .VMERdData(VMERdData),
      .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
      .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .regs_o(regs_o),
      .regs_wr_o(regs_wr_o), .sm_VMEAddr_o(sm_VMEAddr_o),
      .sm_VMERdData_i(sm_VMERdData_i), .sm_VMEWrData_o(sm_VMEWrData_o),
      .sm_VMERdMem_o(sm_VMERdMem_o), .sm_VMEWrMem_o(sm_VMEWrMem_o),
      .sm_VMERdDone_i(sm_VMERdDone_i), .sm_VMEWrDone_i(sm_VMEWrDone_i),
      .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lat(input int l);
      return (l <= TMO) ? l : TMO;
   endfunction

   task automatic check_regs();
      for (int i = 0; i < NREG; i++) begin
         chk("regs_o_word", regs_o[i*32 +: 32], mdl[i]);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) mdl[i] = RSTV;
      tmo_flag = 1'b0;
   endtask

   task automatic clear_timeout();
      timeout_clr_i = 1'b1;
      tick();
      timeout_clr_i = 1'b0;
      tmo_flag = 1'b0;
      chk("timeout_clr", timeout_o, 0);
   endtask

   // One bus transaction (write, read, or both in the same cycle). lw/lr are the submap
   // ack latencies in cycles after the submap strobe; a latency above TMO never completes in time.
   task automatic xact(input bit wr, input bit rd, input logic [2:0] addr, input logic [31:0] wdata,
                       input int lw, input int lr, input logic [31:0] smdata);
      bit          sm;
      int          idx, ew, er, ws, rs, ack_w, ack_r, t_end;
      logic [31:0] exp_rd;
      logic [2:0]  ewr;
      sm = addr[2];
      idx = int'(addr[1:0]);
      ew = -1; er = -1; ws = -1; rs = -1; ack_w = -1; ack_r = -1;
      exp_rd = 32'h0;
      ewr = 3'b000;
      if (wr) begin
         if (sm) begin
            ws = 1;
            ew = ws + lat(lw) + 1;
            ack_w = ws + lw;
            if (lw > TMO) tmo_flag = 1'b1;
         end else begin
            ew = 2;
            if (idx < NREG) begin
               mdl[idx] = wdata;
               ewr = 3'(1 << idx);
            end
         end
      end
      if (rd) begin
         rs = wr ? ew + 1 : 1;
         if (sm) begin
            er = rs + lat(lr) + 1;
            ack_r = rs + lr;
            exp_rd = (lr <= TMO) ? smdata : 32'hFFFFFFFF;
            if (lr > TMO) tmo_flag = 1'b1;
         end else begin
            er = rs + 1;
            exp_rd = (idx < NREG) ? mdl[idx] : 32'h0;
            rs = -1;
         end
      end
      t_end = ((ew > er) ? ew : er) + 2;
      VMEAddr = addr; VMEWrData = wdata; VMEWrMem = wr; VMERdMem = rd;
      tick();
      VMEWrMem = 1'b0; VMERdMem = 1'b0;
      VMEAddr = 3'($urandom); VMEWrData = $urandom;
      for (int t = 1; t <= t_end; t++) begin
         chk("wr_done", VMEWrDone, (t == ew));
         chk("rd_done", VMERdDone, (t == er));
         if (t == er) chk("rd_data", VMERdData, exp_rd);
         chk("sm_wr_strobe", sm_VMEWrMem_o, (t == ws));
         chk("sm_rd_strobe", sm_VMERdMem_o, (t == rs));
         if (t == ws || t == rs) chk("sm_addr", sm_VMEAddr_o, addr[1:0]);
         if (t == ws) chk("sm_wdata", sm_VMEWrData_o, wdata);
         chk("regs_wr", regs_wr_o, (t == ew) ? ewr : 3'b000);
         sm_VMEWrDone_i = (t == ack_w);
         sm_VMERdDone_i = (t == ack_r);
         sm_VMERdData_i = (t == ack_r) ? smdata : $urandom;
         tick();
      end
      sm_VMEWrDone_i = 1'b0;
      sm_VMERdDone_i = 1'b0;
      check_regs();
      chk("timeout_flag", timeout_o, tmo_flag);
   endtask

   initial begin
      Rst = 1'b1;
      VMEAddr = 3'd0; VMEWrData = 32'h0; VMERdMem = 1'b0; VMEWrMem = 1'b0;
      sm_VMERdData_i = 32'h0; sm_VMERdDone_i = 1'b0; sm_VMEWrDone_i = 1'b0;
      timeout_clr_i = 1'b0;
      model_reset();
      tick(); tick();
      Rst = 1'b0;
      tick();

      // reset state
      chk("rst_rddata", VMERdData, 0);
      chk("rst_rddone", VMERdDone, 0);
      chk("rst_wrdone", VMEWrDone, 0);
      chk("rst_regs_wr", regs_wr_o, 0);
      chk("rst_sm_rd", sm_VMERdMem_o, 0);
      chk("rst_sm_wr", sm_VMEWrMem_o, 0);
      chk("rst_sm_addr", sm_VMEAddr_o, 0);
      chk("rst_sm_wdata", sm_VMEWrData_o, 0);
      chk("rst_timeout", timeout_o, 0);
      check_regs();
      xact(1'b0, 1'b1, 3'b010, 32'h0, 0, 0, 32'h0);

      // register write, read-back, unmapped write and read
      xact(1'b1, 1'b0, 3'b001, 32'hCAFEF00D, 0, 0, 32'h0);
      xact(1'b0, 1'b1, 3'b001, 32'h0, 0, 0, 32'h0);
      xact(1'b1, 1'b0, 3'b011, 32'hDEADBEEF, 0, 0, 32'h0);
      xact(1'b0, 1'b1, 3'b011, 32'h0, 0, 0, 32'h0);

      // submap read, timeout and ack-at-limit
      xact(1'b0, 1'b1, 3'b101, 32'h0, 0, 7, 32'hA5A5A5A5);
      xact(1'b1, 1'b0, 3'b110, 32'h600DF00D, 1000, 0, 32'h0);
      clear_timeout();
      xact(1'b1, 1'b0, 3'b110, 32'h13572468, TMO, 0, 32'h0);
      xact(1'b0, 1'b1, 3'b111, 32'h0, 0, TMO + 1, 32'h0);
      clear_timeout();

      // write/read collision on reg 0, then on the submap
      xact(1'b1, 1'b1, 3'b000, 32'h00000001, 0, 0, 32'h0);
      xact(1'b1, 1'b1, 3'b100, 32'h0BADCAFE, 3, 5, 32'h5A5A0FF0);

      // reset in the middle of a submap wait
      VMEAddr = 3'b110; VMERdMem = 1'b1;
      tick();
      VMERdMem = 1'b0;
      repeat (4) tick();
      Rst = 1'b1;
      #2;
      model_reset();
      chk("midrst_rddone", VMERdDone, 0);
      chk("midrst_rddata", VMERdData, 0);
      chk("midrst_sm_addr", sm_VMEAddr_o, 0);
      check_regs();
      tick();
      Rst = 1'b0;
      for (int t = 0; t < 24; t++) begin
         chk("midrst_no_rddone", VMERdDone, 0);
         chk("midrst_no_wrdone", VMEWrDone, 0);
         sm_VMERdDone_i = (t == 5);
         sm_VMEWrDone_i = (t == 9);
         tick();
      end
      sm_VMERdDone_i = 1'b0;
      sm_VMEWrDone_i = 1'b0;
      xact(1'b0, 1'b1, 3'b001, 32'h0, 0, 0, 32'h0);
      xact(1'b0, 1'b1, 3'b110, 32'h0, 0, 4, 32'h31415926);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         xact(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom,
              int'($urandom_range(1, 22)), int'($urandom_range(1, 22)), $urandom);
         if (tmo_flag && $urandom_range(0, 1) == 1) clear_timeout();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
